// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: owns the 128-bit state and AddRoundKey and walks round keys NR..0.
// Latency 2*(NR+1) cycles from accept to out_valid; accepts only in IDLE, and holds the result until out_ready.
module aes_inv_round_ctrl #(
  parameter int NR  = 10,
  parameter int KAW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   data_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   data_out,
  output logic [KAW-1:0] rk_addr,
  output logic           rk_rd_en,
  input  logic [127:0]   rk_data,
  output logic [127:0]   ss_in,
  input  logic [127:0]   ss_out,
  output logic [127:0]   mc_in,
  input  logic [127:0]   mc_out
);

  localparam logic [KAW-1:0] KLAST = KAW'(NR);

  typedef enum logic [1:0] {IDLE, KWAIT, KAPPLY, DONE} fsm_t;

  fsm_t           fsm, fsm_nxt;
  logic [127:0]   state_reg, state_nxt;
  logic [KAW-1:0] k, k_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state_reg <= '0;
      k         <= '0;
    end else begin
      fsm       <= fsm_nxt;
      state_reg <= state_nxt;
      k         <= k_nxt;
    end
  end

  // The key counter is itself the registered RAM address; they never differ.
  assign rk_addr  = k;
  assign data_out = state_reg;
  assign ss_in    = state_reg;
  assign mc_in    = ss_out ^ rk_data;

  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state_reg;
    k_nxt     = k;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_rd_en  = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = data_in;
          k_nxt     = KLAST;
          fsm_nxt   = KWAIT;
        end
      end
      KWAIT: begin
        rk_rd_en = 1'b1;
        fsm_nxt  = KAPPLY;
      end
      KAPPLY: begin
        // First key is a bare AddRoundKey; the last round skips InvMixColumns.
        if (k == KLAST)
          state_nxt = state_reg ^ rk_data;
        else if (k == '0)
          state_nxt = mc_in;
        else
          state_nxt = mc_out;
        if (k == '0) begin
          fsm_nxt = DONE;
        end else begin
          k_nxt   = k - KAW'(1);
          fsm_nxt = KWAIT;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: NR=10 and NR=14 instances with key RAMs and inverse stages modelled here,
// results checked against FIPS-197 vectors and a full inverse-cipher reference function.
module tb_aes_inv_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic         rk_rd_en  [2];
  logic [3:0]   rk_addr   [2];
  logic [127:0] data_in   [2];
  logic [127:0] data_out  [2];
  logic [127:0] rk_data   [2];
  logic [127:0] ss_in     [2];
  logic [127:0] ss_out    [2];
  logic [127:0] mc_in     [2];
  logic [127:0] mc_out    [2];
  logic [127:0] rk10 [0:10];
  logic [127:0] rk14 [0:14];
  int           nchk = 0;
  int           nfail = 0;

  always #5 clk = ~clk;

  // ---------------- GF(2^8) / AES reference helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] t, r;
    t = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    logic [31:0] o;
    for (int j = 0; j < 4; j++) o[8*j +: 8] = sbox(w[8*j +: 8]);
    return o;
  endfunction

  // InvShiftRows then InvSubBytes; byte r+4c is row r, column c.
  function automatic logic [127:0] inv_ss(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r + 4*((c + r) % 4)) +: 8] = isbox(s[8*(r + 4*c) +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++) acc = acc ^ gmul(m[(i - j + 4) % 4], s[8*(4*c + i) +: 8]);
        o[8*(4*c + j) +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] round_key(input int nk, input logic [255:0] key, input int r);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endfunction

  function automatic logic [127:0] rkey(input int sel, input int r);
    return sel != 0 ? rk14[r] : rk10[r];
  endfunction

  // Full FIPS-197 inverse cipher.
  function automatic logic [127:0] aes_dec(input logic [127:0] ct, input int sel);
    int nr;
    logic [127:0] s;
    nr = (sel != 0) ? 14 : 10;
    s = ct ^ rkey(sel, nr);
    for (int r = nr - 1; r >= 1; r--) s = inv_mc(inv_ss(s) ^ rkey(sel, r));
    return inv_ss(s) ^ rkey(sel, 0);
  endfunction

  // FIPS hex strings list byte 0 first; the DUT puts byte 0 in bits 7:0.
  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  // ---------------- DUTs, key RAMs, external stages ----------------
  aes_inv_round_ctrl #(.NR(10), .KAW(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .data_out(data_out[0]), .rk_addr(rk_addr[0]), .rk_rd_en(rk_rd_en[0]),
    .rk_data(rk_data[0]), .ss_in(ss_in[0]), .ss_out(ss_out[0]),
    .mc_in(mc_in[0]), .mc_out(mc_out[0])
  );

  aes_inv_round_ctrl #(.NR(14), .KAW(4)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .data_out(data_out[1]), .rk_addr(rk_addr[1]), .rk_rd_en(rk_rd_en[1]),
    .rk_data(rk_data[1]), .ss_in(ss_in[1]), .ss_out(ss_out[1]),
    .mc_in(mc_in[1]), .mc_out(mc_out[1])
  );

  always @(posedge clk) if (rk_rd_en[0]) rk_data[0] <= rk10[rk_addr[0]];
  always @(posedge clk) if (rk_rd_en[1]) rk_data[1] <= rk14[rk_addr[1]];

  assign ss_out[0] = inv_ss(ss_in[0]);
  assign ss_out[1] = inv_ss(ss_in[1]);
  assign mc_out[0] = inv_mc(mc_in[0]);
  assign mc_out[1] = inv_mc(mc_in[1]);

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called at the first falling edge after the accept edge; returns the falling-edge index
  // at which out_valid is first seen (edges after accept = n-1).
  task automatic wait_out(input int s, output int n);
    int nr;
    int bad_addr;
    int bad_busy;
    nr = (s != 0) ? 14 : 10;
    bad_addr = 0;
    bad_busy = 0;
    n = 1;
    while (!out_valid[s] && n < 200) begin
      if (n <= 2*(nr+1) && int'(rk_addr[s]) != nr - (n-1)/2) bad_addr++;
      if (rk_rd_en[s] !== ((n % 2) == 1)) bad_busy++;
      if (in_ready[s] !== 1'b0) bad_busy++;
      @(negedge clk);
      n++;
    end
    check("out_valid_timeout", n < 200, 1);
    check("rk_addr_sequence", bad_addr, 0);
    check("busy_handshake", bad_busy, 0);
  endtask

  task automatic check_reset_vals(input int s, input string tag);
    check({tag, "_in_ready"}, in_ready[s], 1);
    check({tag, "_out_valid"}, out_valid[s], 0);
    check({tag, "_rk_rd_en"}, rk_rd_en[s], 0);
    check({tag, "_rk_addr"}, rk_addr[s], 0);
    check({tag, "_data_out"}, data_out[s], 0);
  endtask

  typedef struct {
    int           sel;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [6];
    logic [255:0] keyb;
    logic [127:0] c1ct, c1pt, c3ct, ct2, pt2, hold_d;
    int           n, s, bad;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; data_in[i] = '0;
    end
    for (int i = 0; i < 32; i++) keyb[8*i +: 8] = 8'(i);
    for (int r = 0; r <= 10; r++) rk10[r] = round_key(4, keyb, r);
    for (int r = 0; r <= 14; r++) rk14[r] = round_key(8, keyb, r);
    c1ct = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    c1pt = bswap(128'h00112233445566778899aabbccddeeff);
    c3ct = bswap(128'h8ea2b7ca516745bfeafc49904b496089);
    check("model_fips_c1", aes_dec(c1ct, 0), c1pt);

    vecs[0] = '{0, c1ct, c1pt, 22};
    vecs[1] = '{1, c3ct, c1pt, 30};
    for (int i = 2; i < 6; i++) begin
      vecs[i].sel = int'($urandom_range(0, 1));
      vecs[i].ct  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt  = aes_dec(vecs[i].ct, vecs[i].sel);
      vecs[i].lat = (vecs[i].sel != 0) ? 30 : 22;
    end

    #12;
    check_reset_vals(0, "reset10");
    check_reset_vals(1, "reset14");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: decrypt, hold under backpressure with junk in_valid, release.
    for (int i = 0; i < 6; i++) begin
      s = vecs[i].sel;
      check($sformatf("vec%0d_in_ready_idle", i), in_ready[s], 1);
      in_valid[s] = 1'b1;
      data_in[s]  = vecs[i].ct;
      @(negedge clk);
      in_valid[s] = 1'b0;
      wait_out(s, n);
      check($sformatf("vec%0d_latency", i), n - 1, vecs[i].lat);
      check($sformatf("vec%0d_plaintext", i), data_out[s], vecs[i].pt);
      check($sformatf("vec%0d_ss_in", i), ss_in[s], vecs[i].pt);
      hold_d = data_out[s];
      in_valid[s] = 1'b1;
      data_in[s]  = {$urandom, $urandom, $urandom, $urandom};
      bad = 0;
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        if (out_valid[s] !== 1'b1 || in_ready[s] !== 1'b0 || data_out[s] !== hold_d) bad++;
      end
      check($sformatf("vec%0d_backpressure_hold", i), bad, 0);
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b1;
      @(negedge clk);
      out_ready[s] = 1'b0;
      check($sformatf("vec%0d_release_out_valid", i), out_valid[s], 0);
      check($sformatf("vec%0d_release_in_ready", i), in_ready[s], 1);
    end

    // Back-to-back with out_ready tied high and in_valid held across block 1.
    ct2 = {$urandom, $urandom, $urandom, $urandom};
    pt2 = aes_dec(ct2, 0);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    data_in[0]   = c1ct;
    check("b2b_in_ready", in_ready[0], 1);
    @(negedge clk);
    data_in[0] = ct2;
    wait_out(0, n);
    check("b2b_blk1_latency", n - 1, 22);
    check("b2b_blk1_plaintext", data_out[0], c1pt);
    @(negedge clk);
    check("b2b_done_one_cycle", out_valid[0], 0);
    check("b2b_idle_in_ready", in_ready[0], 1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("b2b_second_accept", in_ready[0], 0);
    wait_out(0, n);
    check("b2b_blk2_latency", n - 1, 22);
    check("b2b_blk2_plaintext", data_out[0], pt2);
    @(negedge clk);
    check("b2b_blk2_done_one_cycle", out_valid[0], 0);
    out_ready[0] = 1'b0;

    // Asynchronous reset during KAPPLY at k=5, then a fresh decrypt.
    in_valid[0] = 1'b1;
    data_in[0]  = c1ct;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (11) @(negedge clk);
    check("midrst_pre_addr", rk_addr[0], 5);
    check("midrst_pre_rd_en", rk_rd_en[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals(0, "midrst");
    @(negedge clk);
    check("midrst_no_out_valid", out_valid[0], 0);
    rst_n       = 1'b1;
    in_valid[0] = 1'b1;
    data_in[0]  = c1ct;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("postrst_first_edge_accept", in_ready[0], 0);
    wait_out(0, n);
    check("postrst_latency", n - 1, 22);
    check("postrst_plaintext", data_out[0], c1pt);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("postrst_release", in_ready[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
